// File: rtl/picorv_bus_pkg.sv
// Shared definitions for the picorv32 native-bus initiator: FSM encoding,
// command header fields, strobe constants and well-known addresses.
package picorv_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WR_WAIT,
      ST_WR_BUS,
      ST_RD_BUS,
      ST_RD_OUT
   } state_t;

   localparam int          OP_BIT           = 31;
   localparam logic [3:0]  WSTRB_FULL       = 4'hF;
   localparam logic [3:0]  WSTRB_NONE       = 4'h0;
   localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;
   localparam logic [31:0] ADDR_STEP        = 32'd4;

   // Responder-side MMIO locations, kept here so benches share one definition.
   localparam logic [31:0] MMIO_ADDR_A      = 32'h1000_0004;
   localparam logic [31:0] MMIO_ADDR_B      = 32'h1000_0008;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for an outstanding bus request; pulses timeout on the last
// allowed cycle. TIMEOUT = 0 disables it.
module bus_watchdog #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic active,
   output logic timeout
);

   localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT > 1) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] r_count;
   logic          w_at_last;

   assign w_at_last = (r_count == LAST);
   assign timeout   = (TIMEOUT != 0) && active && w_at_last;

   // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (start) begin
         r_count <= '0;
      end else if (active && !w_at_last) begin
         // NOTE: sequential state always takes non-blocking assignments.
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/picorv_mem_master.sv
// Stream-to-bus initiator: parses header/address/data command words and runs
// picorv32 native-bus writes and reads, returning read data on a stream.
module picorv_mem_master
   import picorv_bus_pkg::*;
#(
   parameter int          LEN_WIDTH = 16,
   parameter int          TIMEOUT   = 256,
   parameter logic [31:0] ERR_WORD  = ERR_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] din,
   input  logic        val_in,
   output logic        ready_upward,
   output logic [31:0] dout,
   output logic        val_out,
   input  logic        ready_downward,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        err
);

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_op;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [31:0]           r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_mem_valid;
   logic [31:0]           r_dout;
   logic                  r_val_out;
   logic                  r_err;

   logic                  w_in_xfer;
   logic                  w_bus_state;
   logic                  w_issue;
   logic                  w_timeout;
   logic                  w_bus_ok;
   logic                  w_bus_to;
   logic                  w_bus_end;
   logic                  w_last;

   assign ready_upward = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_WR_WAIT);
   assign busy         = (r_state != ST_IDLE);
   assign w_in_xfer    = val_in && ready_upward;
   assign w_bus_state  = (r_state == ST_WR_BUS) || (r_state == ST_RD_BUS);
   assign w_issue      = w_bus_state && !r_mem_valid;
   assign w_last       = (r_cnt == LEN_WIDTH'(1));

   // A response on the timeout cycle wins; only a silent responder aborts.
   assign w_bus_ok     = r_mem_valid && mem_ready;
   assign w_bus_to     = w_timeout && !mem_ready;
   assign w_bus_end    = w_bus_ok || w_bus_to;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .resetn  (resetn),
      .start   (w_issue),
      .active  (r_mem_valid),
      .timeout (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves a latch.
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (w_in_xfer) w_next_state = ST_ADDR;
         ST_ADDR: begin
            if (w_in_xfer) begin
               if (r_cnt == '0) w_next_state = ST_IDLE;
               else if (r_op)   w_next_state = ST_WR_WAIT;
               else             w_next_state = ST_RD_BUS;
            end
         end
         ST_WR_WAIT: if (w_in_xfer) w_next_state = ST_WR_BUS;
         ST_WR_BUS:  if (w_bus_end) w_next_state = w_last ? ST_IDLE : ST_WR_WAIT;
         ST_RD_BUS:  if (w_bus_end) w_next_state = ST_RD_OUT;
         ST_RD_OUT:  if (ready_downward) w_next_state = w_last ? ST_IDLE : ST_RD_BUS;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_op        <= 1'b0;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= WSTRB_NONE;
         r_mem_valid <= 1'b0;
         r_dout      <= '0;
         r_val_out   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_in_xfer) begin
                  r_op  <= din[OP_BIT];
                  r_cnt <= din[LEN_WIDTH-1:0];
               end
            end
            ST_ADDR:    if (w_in_xfer) r_addr  <= {din[31:2], 2'b00};
            ST_WR_WAIT: if (w_in_xfer) r_wdata <= din;
            ST_WR_BUS: begin
               if (w_issue) begin
                  r_mem_valid <= 1'b1;
                  r_wstrb     <= WSTRB_FULL;
               end else if (w_bus_end) begin
                  // A timed-out write is dropped; the stream still advances.
                  r_mem_valid <= 1'b0;
                  r_cnt       <= r_cnt - 1'b1;
                  r_addr      <= r_addr + ADDR_STEP;
               end
            end
            ST_RD_BUS: begin
               if (w_issue) begin
                  r_mem_valid <= 1'b1;
                  r_wstrb     <= WSTRB_NONE;
               end else if (w_bus_end) begin
                  r_mem_valid <= 1'b0;
                  r_dout      <= w_bus_ok ? mem_rdata : ERR_WORD;
                  r_val_out   <= 1'b1;
               end
            end
            ST_RD_OUT: begin
               if (ready_downward) begin
                  r_val_out <= 1'b0;
                  r_cnt     <= r_cnt - 1'b1;
                  r_addr    <= r_addr + ADDR_STEP;
               end
            end
            default: ;
         endcase
         if (w_bus_to) r_err <= 1'b1;
      end
   end

   assign mem_valid = r_mem_valid;
   assign mem_instr = 1'b0;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wstrb = r_wstrb;
   assign dout      = r_dout;
   assign val_out   = r_val_out;
   assign err       = r_err;

endmodule

// File: tb/tb_picorv_mem_master.sv
// Directed bench for picorv_mem_master: a small behavioural responder with
// programmable wait states, plus a linear sequence of command streams.
module tb_picorv_mem_master;
   import picorv_bus_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] din;
   logic        val_in;
   logic        ready_upward;
   logic [31:0] dout;
   logic        val_out;
   logic        ready_downward;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   picorv_mem_master #(
      .LEN_WIDTH (16),
      .TIMEOUT   (16),
      .ERR_WORD  (32'hDEADBEEF)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .din            (din),
      .val_in         (val_in),
      .ready_upward   (ready_upward),
      .dout           (dout),
      .val_out        (val_out),
      .ready_downward (ready_downward),
      .mem_valid      (mem_valid),
      .mem_instr      (mem_instr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_ready      (mem_ready),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
      .err            (err)
   );

   always #5 clk = ~clk;

   // Responder: drives on the falling edge, answers after resp_delay wait cycles.
   int          resp_delay = 0;
   bit          silent     = 1'b0;
   int          wcnt       = 0;
   bit          prev_v     = 1'b0;
   int          req_count  = 0;
   int          stab_err   = 0;
   logic [31:0] snap_addr, snap_wdata;
   logic [3:0]  snap_wstrb;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] log_addr[$];
   logic [31:0] log_wdata[$];
   logic [3:0]  log_wstrb[$];
   int          log_vcyc[$];

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!resetn || !mem_valid) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            prev_v    = 1'b0;
         end else begin
            if (!prev_v) begin
               snap_addr  = mem_addr;
               snap_wdata = mem_wdata;
               snap_wstrb = mem_wstrb;
               req_count++;
            end else if (mem_addr !== snap_addr || mem_wdata !== snap_wdata || mem_wstrb !== snap_wstrb) begin
               stab_err++;
            end
            prev_v = 1'b1;
            if (!silent && wcnt == resp_delay) begin
               mem_ready = 1'b1;
               mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
               if (mem_wstrb == WSTRB_FULL) mem[mem_addr] = mem_wdata;
               log_addr.push_back(mem_addr);
               log_wdata.push_back(mem_wdata);
               log_wstrb.push_back(mem_wstrb);
               log_vcyc.push_back(wcnt + 1);
            end else begin
               mem_ready = 1'b0;
               wcnt++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_wdata.delete();
      log_wstrb.delete();
      log_vcyc.delete();
   endtask

   task automatic send(input logic [31:0] w, output int waits);
      val_in = 1'b1;
      din    = w;
      waits  = 0;
      while (!ready_upward && waits < 200) begin
         tick();
         waits++;
      end
      if (!ready_upward) check("send_ready", {31'b0, ready_upward}, 32'd1);
      @(posedge clk);
      tick();
      val_in = 1'b0;
   endtask

   task automatic send2(input logic [31:0] w0, input logic [31:0] w1);
      int w;
      send(w0, w);
      send(w1, w);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      check(tag, {31'b0, busy}, 32'd0);
   endtask

   task automatic wait_val_out(input string tag);
      int n = 0;
      while (!val_out && n < 300) begin
         tick();
         n++;
      end
      check(tag, {31'b0, val_out}, 32'd1);
   endtask

   task automatic wait_mem_valid(input string tag);
      int n = 0;
      while (!mem_valid && n < 300) begin
         tick();
         n++;
      end
      check(tag, {31'b0, mem_valid}, 32'd1);
   endtask

   initial begin
      int w;
      int n;
      int rc;
      int bad;
      resetn         = 1'b0;
      din            = '0;
      val_in         = 1'b0;
      ready_downward = 1'b0;
      repeat (2) tick();

      check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_ready_up", {31'b0, ready_upward}, 32'd1);
      check("rst_val_out", {31'b0, val_out}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_dout", dout, 32'h0);
      resetn = 1'b1;
      tick();

      // Two-word write with 3 wait states per request.
      clear_log();
      resp_delay = 3;
      send2(32'h8000_0002, 32'h0000_0100);
      send(32'hAABB_CCDD, w);
      check("wr_lat_pre", {31'b0, mem_valid}, 32'd0);
      tick();
      check("wr_lat_valid", {31'b0, mem_valid}, 32'd1);
      check("wr_addr0_live", mem_addr, 32'h100);
      check("wr_wstrb_live", {28'b0, mem_wstrb}, 32'hF);
      send(32'h1122_3344, w);
      wait_idle("wr_idle");
      check("wr_count", log_addr.size(), 32'd2);
      check("wr_addr0", log_addr[0], 32'h100);
      check("wr_data0", log_wdata[0], 32'hAABB_CCDD);
      check("wr_strb0", {28'b0, log_wstrb[0]}, 32'hF);
      check("wr_addr1", log_addr[1], 32'h104);
      check("wr_data1", log_wdata[1], 32'h1122_3344);
      check("wr_hold_cycles", log_vcyc[0], 32'd4);
      check("wr_stable", stab_err, 32'd0);
      check("mem_instr", {31'b0, mem_instr}, 32'd0);

      // Read-back with downstream stalled for 5 cycles on the first word.
      clear_log();
      resp_delay     = 0;
      ready_downward = 1'b0;
      send2(32'h0000_0002, 32'h0000_0100);
      n = 0;
      while (!mem_ready && n < 300) begin
         tick();
         n++;
      end
      check("rd_saw_ready", {31'b0, mem_ready}, 32'd1);
      check("rd_lat_pre", {31'b0, val_out}, 32'd0);
      tick();
      check("rd_lat_val", {31'b0, val_out}, 32'd1);
      check("rd_dout0", dout, 32'hAABB_CCDD);
      rc  = req_count;
      bad = 0;
      repeat (5) begin
         tick();
         if (val_out !== 1'b1 || dout !== 32'hAABB_CCDD || mem_valid !== 1'b0) bad++;
      end
      check("rd_hold", bad, 32'd0);
      check("rd_no_second_req", req_count, rc);
      ready_downward = 1'b1;
      tick();
      ready_downward = 1'b0;
      wait_val_out("rd_wait1");
      check("rd_dout1", dout, 32'h1122_3344);
      ready_downward = 1'b1;
      tick();
      ready_downward = 1'b0;
      wait_idle("rd_idle");
      check("rd_addr0", log_addr[0], 32'h100);
      check("rd_addr1", log_addr[1], 32'h104);
      check("rd_strb", {28'b0, log_wstrb[1]}, 32'h0);

      // Zero-length command: no bus request, back in IDLE at once.
      rc = req_count;
      send2(32'h8000_0000, 32'h0000_0200);
      check("zl_busy", {31'b0, busy}, 32'd0);
      check("zl_ready", {31'b0, ready_upward}, 32'd1);
      send(32'h0000_0000, w);
      check("zl_next_hdr_waits", w, 32'd0);
      send(32'h0000_0000, w);
      tick();
      check("zl_no_req", req_count, rc);

      // Response on the final watchdog cycle counts as success.
      resp_delay     = 15;
      ready_downward = 1'b1;
      send2(32'h0000_0001, 32'h0000_0104);
      wait_val_out("edge_wait");
      check("edge_dout", dout, 32'h1122_3344);
      check("edge_err", {31'b0, err}, 32'd0);
      wait_idle("edge_idle");

      // Silent responder: watchdog aborts after 16 cycles.
      silent         = 1'b1;
      ready_downward = 1'b0;
      send2(32'h0000_0001, 32'h0000_0300);
      wait_mem_valid("to_wait_valid");
      n = 0;
      while (mem_valid && n < 100) begin
         n++;
         tick();
      end
      check("to_valid_len", n, 32'd16);
      check("to_err", {31'b0, err}, 32'd1);
      wait_val_out("to_wait_val");
      check("to_dout", dout, 32'hDEAD_BEEF);
      ready_downward = 1'b1;
      tick();
      ready_downward = 1'b0;
      wait_idle("to_idle");
      silent     = 1'b0;
      resp_delay = 0;
      send2(32'h0000_0001, 32'h0000_0100);
      wait_val_out("to_good_wait");
      check("to_good_dout", dout, 32'hAABB_CCDD);
      check("to_err_sticky", {31'b0, err}, 32'd1);
      ready_downward = 1'b1;
      tick();
      ready_downward = 1'b0;
      wait_idle("to_good_idle");

      // Address wrap across the top of the 32-bit space.
      clear_log();
      ready_downward = 1'b1;
      send2(32'h0000_0002, 32'hFFFF_FFFE);
      wait_idle("wrap_idle");
      ready_downward = 1'b0;
      check("wrap_count", log_addr.size(), 32'd2);
      check("wrap_addr0", log_addr[0], 32'hFFFF_FFFC);
      check("wrap_addr1", log_addr[1], 32'h0000_0000);

      // Reset while a write request is outstanding.
      resp_delay = 10;
      send2(32'h8000_0001, 32'h0000_0400);
      send(32'h0000_0055, w);
      wait_mem_valid("mid_wait_valid");
      resetn = 1'b0;
      tick();
      check("mid_mem_valid", {31'b0, mem_valid}, 32'd0);
      check("mid_busy", {31'b0, busy}, 32'd0);
      check("mid_ready_up", {31'b0, ready_upward}, 32'd1);
      check("mid_err", {31'b0, err}, 32'd0);
      check("mid_wstrb", {28'b0, mem_wstrb}, 32'd0);
      check("mid_addr", mem_addr, 32'h0);
      check("mid_wdata", mem_wdata, 32'h0);
      resetn = 1'b1;
      tick();
      clear_log();
      resp_delay = 0;
      send2(32'h8000_0001, 32'h0000_0400);
      send(32'h0000_0066, w);
      wait_idle("post_wr_idle");
      check("post_wr_count", log_addr.size(), 32'd1);
      check("post_wr_addr", log_addr[0], 32'h400);
      check("post_wr_data", log_wdata[0], 32'h66);
      ready_downward = 1'b1;
      send2(32'h0000_0001, 32'h0000_0400);
      wait_val_out("post_rd_wait");
      check("post_rd_dout", dout, 32'h66);
      wait_idle("post_rd_idle");
      ready_downward = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
